// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit).
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } piso_state_e;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Counter width wide enough for DATA_WIDTH plus a parity bit.
  function automatic int bits_left_w(input int dw);
    return $clog2(dw + 2);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with terminal-count flag.
// Optional feature macro: none (width set by parent).
module piso_bit_counter #(
  parameter int W = 4
) (
  input  logic         Clk_In,
  input  logic         Reset_n_In,
  input  logic         Load_In,
  input  logic [W-1:0] Load_Val_In,
  input  logic         Clr_In,
  input  logic         Dec_In,
  output logic [W-1:0] Count_Out,
  output logic         Last_Out
);

  // Load wins over clear, clear wins over decrement.
  always_ff @(negedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      Count_Out <= '0;
    end else if (Load_In) begin
      Count_Out <= Load_Val_In;
    end else if (Clr_In) begin
      Count_Out <= '0;
    end else if (Dec_In) begin
      Count_Out <= Count_Out - 1'b1;
    end
  end

  // Current bit is the final bit of the frame.
  assign Last_Out = (Count_Out == W'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, valid/ready load, falling-edge state.
// Optional feature macro: PISO_PARITY_EN (even-parity bit after data).
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_n_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Load_Valid_In,
  output logic                  Load_Ready_Out,
  input  logic                  Shift_En_In,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic [bits_left_w(DATA_WIDTH)-1:0] Bits_Left_Out,
  output logic                  Frame_Done_Out
);

  localparam int BW = bits_left_w(DATA_WIDTH);
  localparam int FRAME = DATA_WIDTH + PARITY_BITS;
  localparam logic [BW-1:0] FRAME_LEN = BW'(FRAME);

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Move one position toward the output end, back-filling idle level.
  function automatic word_t shift1(input word_t v);
    if (MSB_FIRST) begin
      return {v[DATA_WIDTH-2:0], IDLE_LEVEL};
    end
    return {IDLE_LEVEL, v[DATA_WIDTH-1:1]};
  endfunction

  // Bit sitting at the output end of a word.
  function automatic logic head(input word_t v);
    return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
  endfunction

  piso_state_e state_q, state_d;
  word_t       sreg_q, sreg_d;
  logic        ser_q, ser_d;
  logic        vld_q, vld_d;
  logic        done_q, done_d;
`ifdef PISO_PARITY_EN
  logic        par_q, par_d;
`endif

  logic          cnt_load;
  logic          cnt_clr;
  logic          cnt_dec;
  logic [BW-1:0] cnt;
  logic          cnt_last;

  logic busy;
  logic step;
  logic retire;
  logic accept;

  piso_bit_counter #(
    .W (BW)
  ) u_cnt (
    .Clk_In      (Clk_In),
    .Reset_n_In  (Reset_n_In),
    .Load_In     (cnt_load),
    .Load_Val_In (FRAME_LEN),
    .Clr_In      (cnt_clr),
    .Dec_In      (cnt_dec),
    .Count_Out   (cnt),
    .Last_Out    (cnt_last)
  );

  assign busy   = (state_q != IDLE);
  assign step   = busy & Shift_En_In;
  assign retire = step & cnt_last;

  // Ready when idle, or when the final bit retires on this edge.
  assign Load_Ready_Out = !busy | (cnt_last & Shift_En_In);
  assign accept = Load_Valid_In & Load_Ready_Out;

  // Next-state and datapath decode.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    ser_d    = ser_q;
    vld_d    = vld_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_dec  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d    = par_q;
`endif
    if (accept) begin
      state_d  = SHIFT;
      sreg_d   = shift1(Parallel_Data_In);
      ser_d    = head(Parallel_Data_In);
      vld_d    = 1'b1;
      cnt_load = 1'b1;
      done_d   = retire;
`ifdef PISO_PARITY_EN
      par_d    = ^Parallel_Data_In;
`endif
    end else if (retire) begin
      state_d = IDLE;
      sreg_d  = {DATA_WIDTH{IDLE_LEVEL}};
      ser_d   = IDLE_LEVEL;
      vld_d   = 1'b0;
      cnt_clr = 1'b1;
      done_d  = 1'b1;
    end else if (step) begin
      cnt_dec = 1'b1;
`ifdef PISO_PARITY_EN
      if (state_q == SHIFT && cnt == BW'(2)) begin
        state_d = PARITY;
        ser_d   = par_q;
      end else begin
        ser_d  = head(sreg_q);
        sreg_d = shift1(sreg_q);
      end
`else
      ser_d  = head(sreg_q);
      sreg_d = shift1(sreg_q);
`endif
    end
  end

  // State and output registers; reset abandons any frame silently.
  always_ff @(negedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= IDLE;
      sreg_q  <= {DATA_WIDTH{IDLE_LEVEL}};
      ser_q   <= IDLE_LEVEL;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      ser_q   <= ser_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Serial_Data_Out  = ser_q;
  assign Serial_Valid_Out = vld_q;
  assign Bits_Left_Out    = cnt;
  assign Frame_Done_Out   = done_q;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order, shift-enable pacing, and frame-done signalling. It converts DATA_WIDTH-bit words into a continuous serial stream. It is the general-purpose successor to the fixed 8-bit PISO register and sits between a word-oriented producer and a bit-serial line driver (UART/SPI-style transmitters).

## Interface
- DATA_WIDTH, 8: parallel word width, ≥2
- MSB_FIRST, 0: 0 = bit 0 shifted out first, 1 = bit DATA_WIDTH-1 first
- IDLE_LEVEL, 1'b1: line level when idle and fill value for vacated bits
- Clk_In  input  1  clock; all state updates on falling edge
- Reset_n_In  input  1  asynchronous, active-low reset
- Parallel_Data_In  input  DATA_WIDTH  word to serialize
- Load_Valid_In  input  1  producer offers Parallel_Data_In
- Load_Ready_Out  output  1  serializer can accept a word this cycle
- Shift_En_In  input  1  bit-time strobe; a shift occurs only on edges where it is 1
- Serial_Data_Out  output  1  registered serial bit
- Serial_Valid_Out  output  1  Serial_Data_Out carries frame data (or parity)
- Bits_Left_Out  output  $clog2(DATA_WIDTH+2)  bits remaining in frame, including the current bit
- Frame_Done_Out  output  1  one-cycle pulse after the last bit of a frame retires

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with PISO_PARITY_EN).
- Reset values: state IDLE, shift register all IDLE_LEVEL, Serial_Data_Out = IDLE_LEVEL, Serial_Valid_Out 0, Bits_Left_Out 0, Frame_Done_Out 0.
- Load_Ready_Out is combinational: 1 in IDLE; 1 in SHIFT/PARITY only when the current bit is the last of the frame and Shift_En_In = 1; otherwise 0.
- Accept = Load_Valid_In & Load_Ready_Out. On accept, the word is captured and the first bit is driven on Serial_Data_Out. State → SHIFT, Serial_Valid_Out = 1, Bits_Left_Out = DATA_WIDTH (+1 with parity).
- SHIFT, Shift_En_In = 1, not the last bit: shift one position toward the output end, fill the vacated bit with IDLE_LEVEL, and decrement Bits_Left_Out.
- SHIFT, Shift_En_In = 0: everything holds.
- Last data bit retires with parity enabled → PARITY.
- Last bit retires (data or parity), no accept → IDLE. Serial_Data_Out = IDLE_LEVEL, Serial_Valid_Out 0, Bits_Left_Out 0, Frame_Done_Out 1 for one cycle.
- Last bit retires with a simultaneous accept → the new frame starts with no idle bit. Frame_Done_Out still pulses.
- Load_Valid_In while not ready is ignored. The producer holds the data until accepted.
- Reset asserted mid-frame: the frame is abandoned immediately and all outputs return to reset values. No Frame_Done_Out pulse.

## Timing
- Load-to-first-bit: 1 edge. The first bit is visible after the accepting edge, independent of Shift_En_In.
- Frame length: DATA_WIDTH (+1 with parity) Shift_En_In-qualified edges, counted from the accept.
- Continuous Shift_En_In = 1 with Load_Valid_In held high gives a gapless stream: one bit per cycle, 100% line utilisation.
- Frame_Done_Out is registered and is never high for two consecutive cycles when DATA_WIDTH ≥ 2.

## Configuration
- PISO_PARITY_EN defined: one even-parity bit (XOR of the captured word) is appended after the data bits. This adds the PARITY state and widens the frame by one bit.
- PISO_PARITY_EN undefined: no PARITY state and no parity logic. The frame is exactly DATA_WIDTH bits.

## Structure
- Package piso_pkg: the state enum (IDLE, SHIFT, PARITY) and a bits-left width function derived from DATA_WIDTH.
- One sub-module, piso_bit_counter: loadable down-counter with a terminal-count flag. It drives Bits_Left_Out and the last-bit decode.

## Test plan
- Reset: hold Reset_n_In low for 3 cycles → Serial_Data_Out = 1, Serial_Valid_Out = 0, Load_Ready_Out = 1, Bits_Left_Out = 0.
- LSB-first, DATA_WIDTH = 8, load 8'hA5, Shift_En_In = 1 → serial 1,0,1,0,0,1,0,1. Then Frame_Done_Out pulses once and the line returns to 1.
- MSB-first, load 8'hA5 → serial 1,0,1,0,0,1,0,1 in MSB order. Bits_Left_Out counts 8 down to 1.
- Shift_En_In every 4th cycle, load 8'h0F → each bit held for 4 cycles, 32 cycles per frame, Load_Ready_Out low until the last bit.
- Back-to-back loads 8'hFF then 8'h00 with Load_Valid_In held high → 16 contiguous bits with no idle gap, and two Frame_Done_Out pulses.
- PISO_PARITY_EN, load 8'h07 → 8 data bits then parity 1. Reset_n_In low at bit 4 of the next frame → outputs immediately at reset values, no Frame_Done_Out.
